v_init_mb: RTL and testbench
============================

V_INIT_MB -- requirements
Module: v_init_mb

Interface
REQ-001 Parameter N, default 16: words per bank; SHALL be >= 2; AW = $clog2(N).
REQ-002 Parameter W, default 32: word width; SHALL be >= 1.
REQ-003 Parameter B, default 2: bank (channel) count; SHALL be >= 1.
REQ-004 clk  in  1  sole clock; all flops rise-edge.
REQ-005 arst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_start  in  1  request initialization; sampled only in IDLE.
REQ-007 i_mode  in  2  fill mode: 0 zero, 1 pattern, 2 address-index, 3 inverted pattern.
REQ-008 i_pattern  in  W  fill constant for modes 1/3.
REQ-009 i_bank_mask  in  B  banks to initialize.
REQ-010 i_stall  in  1  memory backpressure; suppresses next write.
REQ-011 i_abort  in  1  terminate operation in progress.
REQ-012 o_wen_r  out  B  per-bank write enable, registered.
REQ-013 o_waddr_r  out  AW  write address shared by all banks, registered.
REQ-014 o_wdata_r  out  W  write data shared by all banks, registered.
REQ-015 o_busy_r  out  1  operation in progress, registered.
REQ-016 o_done_r  out  1  one-cycle pulse on normal completion, registered.
REQ-017 o_aborted_r  out  1  one-cycle pulse on abort, registered.

Function
REQ-018 FSM SHALL be one-hot states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE + i_start SHALL latch i_mode, i_pattern, i_bank_mask, clear address counter, enter BUSY; i_start in BUSY/DONE SHALL be ignored.
REQ-020 Start sampled at edge c0 with nonzero mask: o_busy_r=1 and first write (addr 0, o_wen_r=latched mask) SHALL appear in cycle c1.
REQ-021 In BUSY, i_stall=1 in cycle t SHALL force o_wen_r=0 in t+1 with o_waddr_r/o_wdata_r held; i_stall=0 SHALL issue next address in t+1.
REQ-022 Address SHALL increment by 1 only per issued write; after address N-1 issued, FSM SHALL enter DONE; no wrap, no address >= N issued.
REQ-023 DONE SHALL last one cycle: o_done_r=1, o_busy_r=0, o_wen_r=0; then IDLE; stall-free run: writes c1..cN, o_done_r in cN+1.
REQ-024 i_abort in BUSY SHALL take priority over stall/completion: next cycle o_wen_r=0, o_busy_r=0, o_aborted_r=1, state IDLE; i_abort outside BUSY ignored.
REQ-025 i_abort coincident with the final-address cycle SHALL yield abort (o_aborted_r), not o_done_r.
REQ-026 Start with i_bank_mask=0 SHALL issue no writes and pulse o_done_r in c1 with o_busy_r=0.
REQ-027 o_wdata_r: mode0 '0; mode1 pattern; mode2 address zero-extended/truncated to W; mode3 ~pattern.
REQ-028 o_wdata_r and o_waddr_r SHALL be 0 whenever o_wen_r=0 outside BUSY.
REQ-029 Latched configuration SHALL be stable for the whole operation regardless of input changes.

Reset
REQ-030 arst_n low SHALL immediately force IDLE, all outputs 0, counter 0, latched config 0, including mid-operation.
REQ-031 After arst_n release no write SHALL occur until a new i_start.

Configuration
REQ-032 Macro V_INIT_MB_ADDR_PATTERN_EN defined: mode 2 writes address-index data per REQ-027.
REQ-033 Macro absent: mode 2 SHALL behave exactly as mode 0 and address-to-data logic SHALL not be synthesized.

Verification (N=8, W=8, B=2)
REQ-034 Reset, start mode1 pattern 0xA5 mask 2'b11, no stall -> o_wen_r=2'b11 addr 0..7 in c1..c8 data 0xA5; o_done_r in c9 only.
REQ-035 Start mode2 mask 2'b01, i_stall=1 in c2,c3 -> addr 2 delayed to c5, data==addr (macro on) / 0x00 (macro off); done c11.
REQ-036 Start mode3 pattern 0x0F, i_abort in c4 -> last write addr 3, c5 o_wen_r=0, o_aborted_r=1, no o_done_r.
REQ-037 Start mask 2'b00 -> no o_wen_r, o_done_r=1 in c1; second i_start in c3 of a run ignored.
REQ-038 arst_n low in c4 of a run -> all outputs 0 asynchronously; idle until next i_start.

Source files
------------

// File: rtl/v_init_mb.sv
// v_init_mb: multi-bank memory initializer.
//
// Streams one write per cycle through addresses 0..N-1 to every bank selected
// by the latched bank mask, then pulses o_done_r. Backpressure (i_stall) holds
// the current address/data with write enables dropped; i_abort ends a run early
// with an o_aborted_r pulse.
//
// Ports:
//   clk, arst_n       clock, asynchronous active-low reset
//   i_start           start request, sampled only while idle
//   i_mode            fill mode: 0 zero, 1 pattern, 2 address-index, 3 ~pattern
//   i_pattern         fill constant for modes 1 and 3
//   i_bank_mask       banks to write
//   i_stall           suppress the next write
//   i_abort           terminate the run in progress
//   o_wen_r           per-bank write enable
//   o_waddr_r         shared write address
//   o_wdata_r         shared write data
//   o_busy_r          run in progress
//   o_done_r          one-cycle pulse on normal completion
//   o_aborted_r       one-cycle pulse on abort
//
// Build option: define V_INIT_MB_ADDR_PATTERN_EN to enable address-index data
// for mode 2; without it mode 2 writes zeros and no address-to-data path exists.

module v_init_mb #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 32,
    parameter int unsigned B = 2,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_start,
    input  logic [1:0]    i_mode,
    input  logic [W-1:0]  i_pattern,
    input  logic [B-1:0]  i_bank_mask,
    input  logic          i_stall,
    input  logic          i_abort,
    output logic [B-1:0]  o_wen_r,
    output logic [AW-1:0] o_waddr_r,
    output logic [W-1:0]  o_wdata_r,
    output logic          o_busy_r,
    output logic          o_done_r,
    output logic          o_aborted_r
);

    // Counter must hold N itself: it counts writes issued, so it also serves
    // as the next address to issue.
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] CntAll = CW'(N);

    localparam logic [1:0] ModePat = 2'd1;
    localparam logic [1:0] ModeInv = 2'd3;
`ifdef V_INIT_MB_ADDR_PATTERN_EN
    localparam logic [1:0] ModeAddr = 2'd2;
`endif

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StBusy = 3'b010,
        StDone = 3'b100
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [W-1:0]  pattern_q, pattern_d;
    logic [B-1:0]  mask_q, mask_d;

    logic [B-1:0]  wen_d;
    logic [AW-1:0] waddr_d;
    logic [W-1:0]  wdata_d;
    logic          busy_d, done_d, aborted_d;

    // Fill source: live inputs for the first write at start, latched config after.
    logic          in_busy;
    logic [1:0]    fill_mode;
    logic [W-1:0]  fill_pat;
    logic [AW-1:0] issue_addr;
    logic [W-1:0]  fill_word;

    assign in_busy    = (state_q == StBusy);
    assign fill_mode  = in_busy ? mode_q : i_mode;
    assign fill_pat   = in_busy ? pattern_q : i_pattern;
    assign issue_addr = in_busy ? cnt_q[AW-1:0] : '0;

`ifdef V_INIT_MB_ADDR_PATTERN_EN
    logic [W-1:0] addr_word;
    if (W > AW) begin : g_addr_ext
        assign addr_word = {{(W - AW){1'b0}}, issue_addr};
    end else begin : g_addr_trunc
        assign addr_word = issue_addr[W-1:0];
    end
`endif

    always_comb begin
        fill_word = '0;
        case (fill_mode)
            ModePat: fill_word = fill_pat;
            ModeInv: fill_word = ~fill_pat;
`ifdef V_INIT_MB_ADDR_PATTERN_EN
            ModeAddr: fill_word = addr_word;
`endif
            default: fill_word = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        mask_d    = mask_q;
        wen_d     = '0;
        waddr_d   = '0;
        wdata_d   = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    mode_d    = i_mode;
                    pattern_d = i_pattern;
                    mask_d    = i_bank_mask;
                    if (i_bank_mask == '0) begin
                        // Nothing to write: complete immediately.
                        cnt_d   = '0;
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        // First write goes out with the start itself.
                        cnt_d   = CW'(1);
                        state_d = StBusy;
                        busy_d  = 1'b1;
                        wen_d   = i_bank_mask;
                        waddr_d = '0;
                        wdata_d = fill_word;
                    end
                end
            end
            StBusy: begin
                if (i_abort) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else if (cnt_q == CntAll) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (i_stall) begin
                    busy_d  = 1'b1;
                    waddr_d = o_waddr_r;
                    wdata_d = o_wdata_r;
                end else begin
                    busy_d  = 1'b1;
                    wen_d   = mask_q;
                    waddr_d = issue_addr;
                    wdata_d = fill_word;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mode_q      <= '0;
            pattern_q   <= '0;
            mask_q      <= '0;
            o_wen_r     <= '0;
            o_waddr_r   <= '0;
            o_wdata_r   <= '0;
            o_busy_r    <= 1'b0;
            o_done_r    <= 1'b0;
            o_aborted_r <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            mask_q      <= mask_d;
            o_wen_r     <= wen_d;
            o_waddr_r   <= waddr_d;
            o_wdata_r   <= wdata_d;
            o_busy_r    <= busy_d;
            o_done_r    <= done_d;
            o_aborted_r <= aborted_d;
        end
    end

endmodule

// File: tb/tb_v_init_mb.sv
// Directed bench for v_init_mb with N=8, W=8, B=2.
module tb_v_init_mb;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       i_start;
    logic [1:0] i_mode;
    logic [7:0] i_pattern;
    logic [1:0] i_bank_mask;
    logic       i_stall;
    logic       i_abort;
    logic [1:0] o_wen_r;
    logic [2:0] o_waddr_r;
    logic [7:0] o_wdata_r;
    logic       o_busy_r;
    logic       o_done_r;
    logic       o_aborted_r;

    int checks = 0;
    int errors = 0;

    v_init_mb #(
        .N(8),
        .W(8),
        .B(2)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_start    (i_start),
        .i_mode     (i_mode),
        .i_pattern  (i_pattern),
        .i_bank_mask(i_bank_mask),
        .i_stall    (i_stall),
        .i_abort    (i_abort),
        .o_wen_r    (o_wen_r),
        .o_waddr_r  (o_waddr_r),
        .o_wdata_r  (o_wdata_r),
        .o_busy_r   (o_busy_r),
        .o_done_r   (o_done_r),
        .o_aborted_r(o_aborted_r)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] wen, input logic [2:0] addr,
                           input logic [7:0] data, input logic busy, input logic done,
                           input logic ab);
        chk({tag, ".wen"},     32'(o_wen_r),     32'(wen));
        chk({tag, ".addr"},    32'(o_waddr_r),   32'(addr));
        chk({tag, ".data"},    32'(o_wdata_r),   32'(data));
        chk({tag, ".busy"},    32'(o_busy_r),    32'(busy));
        chk({tag, ".done"},    32'(o_done_r),    32'(done));
        chk({tag, ".aborted"}, 32'(o_aborted_r), 32'(ab));
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] addr_data(input int k);
`ifdef V_INIT_MB_ADDR_PATTERN_EN
        return 8'(k);
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        arst_n      = 1'b0;
        i_start     = 1'b0;
        i_mode      = 2'd0;
        i_pattern   = 8'h00;
        i_bank_mask = 2'b00;
        i_stall     = 1'b0;
        i_abort     = 1'b0;

        // Reset state
        #12;
        chk_all("reset", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        arst_n = 1'b1;
        tick();
        tick();
        chk_all("post_reset_idle", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Mode 1, pattern A5, both banks, no stall; inputs scrambled after start
        i_start = 1'b1; i_mode = 2'd1; i_pattern = 8'hA5; i_bank_mask = 2'b11;
        tick();
        i_start = 1'b0; i_mode = 2'd0; i_pattern = 8'h3C; i_bank_mask = 2'b00;
        for (int k = 0; k < 8; k++) begin
            chk_all($sformatf("m1_c%0d", k + 1), 2'b11, 3'(k), 8'hA5, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_all("m1_done", 2'b00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("m1_idle", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Mode 2, bank 0, stall in c2 and c3
        i_start = 1'b1; i_mode = 2'd2; i_bank_mask = 2'b01;
        tick();
        i_start = 1'b0;
        chk_all("m2_c1", 2'b01, 3'd0, addr_data(0), 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("m2_c2", 2'b01, 3'd1, addr_data(1), 1'b1, 1'b0, 1'b0);
        i_stall = 1'b1;
        tick();
        chk_all("m2_c3_stall", 2'b00, 3'd1, addr_data(1), 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("m2_c4_stall", 2'b00, 3'd1, addr_data(1), 1'b1, 1'b0, 1'b0);
        i_stall = 1'b0;
        tick();
        for (int k = 2; k < 8; k++) begin
            chk_all($sformatf("m2_c%0d", k + 3), 2'b01, 3'(k), addr_data(k), 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_all("m2_done_c11", 2'b00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();

        // Mode 3, pattern 0F, abort in c4
        i_start = 1'b1; i_mode = 2'd3; i_pattern = 8'h0F; i_bank_mask = 2'b11;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_all($sformatf("m3_c%0d", k + 1), 2'b11, 3'(k), 8'hF0, 1'b1, 1'b0, 1'b0);
            if (k == 3) i_abort = 1'b1;
            tick();
        end
        i_abort = 1'b0;
        chk_all("m3_abort_c5", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("m3_c6_no_done", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Abort while idle is ignored
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk_all("idle_abort_ignored", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Abort coincident with the final-address cycle wins over done
        i_start = 1'b1; i_mode = 2'd1; i_pattern = 8'h5A; i_bank_mask = 2'b10;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_all($sformatf("fin_c%0d", k + 1), 2'b10, 3'(k), 8'h5A, 1'b1, 1'b0, 1'b0);
            if (k == 7) i_abort = 1'b1;
            tick();
        end
        i_abort = 1'b0;
        chk_all("fin_abort", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("fin_idle", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Empty mask: done in c1, no writes
        i_start = 1'b1; i_mode = 2'd1; i_pattern = 8'hFF; i_bank_mask = 2'b00;
        tick();
        i_start = 1'b0;
        chk_all("mask0_c1", 2'b00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("mask0_c2", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Second start from c3 through the DONE cycle is ignored
        i_start = 1'b1; i_mode = 2'd1; i_pattern = 8'h11; i_bank_mask = 2'b01;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 0) i_start = 1'b0;
            if (k == 2) begin
                i_start = 1'b1; i_mode = 2'd3; i_pattern = 8'hFF; i_bank_mask = 2'b11;
            end
            chk_all($sformatf("restart_c%0d", k + 1), 2'b01, 3'(k), 8'h11, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_all("restart_done", 2'b00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        i_start = 1'b0;
        chk_all("restart_c10", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("restart_c11", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in c4 of a run
        i_start = 1'b1; i_mode = 2'd1; i_pattern = 8'h77; i_bank_mask = 2'b11;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_all($sformatf("rst_c%0d", k + 1), 2'b11, 3'(k), 8'h77, 1'b1, 1'b0, 1'b0);
            if (k < 3) tick();
        end
        #2;
        arst_n = 1'b0;
        #1;
        chk_all("rst_async", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        tick();
        chk_all("rst_after_idle", 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // New run after reset starts from address 0
        i_start = 1'b1; i_mode = 2'd1; i_pattern = 8'h99; i_bank_mask = 2'b11;
        tick();
        i_start = 1'b0;
        chk_all("rst_rerun_c1", 2'b11, 3'd0, 8'h99, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("rst_rerun_c2", 2'b11, 3'd1, 8'h99, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
